// File: rtl/pc_rx_packet_decoder.sv
// UART RX byte stream to command packet decoder: sync hunt, length-driven word assembly,
// inter-byte timeout. Define PKT_CHECKSUM_EN to expect and verify a trailing XOR checksum byte.
module pc_rx_packet_decoder #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_rx_byte_valid,
    input  logic        i_fifo_full,
    output logic [31:0] o_fifo_write_word,
    output logic        o_fifo_write_cmd,
    output logic [1:0]  o_packet_command,
    output logic        o_packet_start_decode,
    output logic        o_packet_fully_decoded,
    output logic        o_cmd_error,
    output logic        o_checksum_error,
    output logic        o_timeout_error,
    output logic        o_overflow_error
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CSUM    = 3'd4;

    logic [2:0]  state;
    logic [7:0]  word_cnt;
    logic [1:0]  byte_idx;
    logic [31:0] word_reg;
    logic [23:0] tmo_cnt;
    logic        tmo_hit;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]  csum;
`else
    assign o_checksum_error = 1'b0;
`endif

    assign o_fifo_write_word = word_reg;
    // A byte landing in the expiry cycle takes priority over the timeout.
    assign tmo_hit = (state != ST_IDLE) && !i_rx_byte_valid &&
                     (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state                  <= ST_IDLE;
            word_cnt               <= '0;
            byte_idx               <= '0;
            word_reg               <= '0;
            tmo_cnt                <= '0;
            o_fifo_write_cmd       <= 1'b0;
            o_packet_command       <= 2'h1;
            o_packet_start_decode  <= 1'b0;
            o_packet_fully_decoded <= 1'b0;
            o_cmd_error            <= 1'b0;
            o_timeout_error        <= 1'b0;
            o_overflow_error       <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            csum                   <= '0;
            o_checksum_error       <= 1'b0;
`endif
        end else begin
            o_fifo_write_cmd       <= 1'b0;
            o_packet_start_decode  <= 1'b0;
            o_packet_fully_decoded <= 1'b0;
            o_cmd_error            <= 1'b0;
            o_timeout_error        <= 1'b0;
            o_overflow_error       <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            o_checksum_error       <= 1'b0;
`endif
            if (state == ST_IDLE || i_rx_byte_valid)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 24'd1;

            if (tmo_hit) begin
                o_timeout_error <= 1'b1;
                state           <= ST_IDLE;
            end else if (i_rx_byte_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (i_rx_byte == SYNC_BYTE)
                            state <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (i_rx_byte[1:0] == 2'd0) begin
                            o_cmd_error <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            o_packet_command      <= i_rx_byte[1:0];
                            o_packet_start_decode <= 1'b1;
                            state                 <= ST_LEN;
                        end
`ifdef PKT_CHECKSUM_EN
                        csum <= i_rx_byte;
`endif
                    end
                    ST_LEN: begin
                        word_cnt <= i_rx_byte;
                        byte_idx <= '0;
`ifdef PKT_CHECKSUM_EN
                        csum <= csum ^ i_rx_byte;
                        state <= (i_rx_byte == 8'd0) ? ST_CSUM : ST_PAYLOAD;
`else
                        if (i_rx_byte == 8'd0) begin
                            o_packet_fully_decoded <= 1'b1;
                            state                  <= ST_IDLE;
                        end else begin
                            state <= ST_PAYLOAD;
                        end
`endif
                    end
                    ST_PAYLOAD: begin
                        word_reg <= {word_reg[23:0], i_rx_byte};
                        byte_idx <= byte_idx + 2'd1;
`ifdef PKT_CHECKSUM_EN
                        csum <= csum ^ i_rx_byte;
`endif
                        if (byte_idx == 2'd3) begin
                            if (i_fifo_full)
                                o_overflow_error <= 1'b1;
                            else
                                o_fifo_write_cmd <= 1'b1;
                            word_cnt <= word_cnt - 8'd1;
                            if (word_cnt == 8'd1) begin
`ifdef PKT_CHECKSUM_EN
                                state <= ST_CSUM;
`else
                                o_packet_fully_decoded <= 1'b1;
                                state                  <= ST_IDLE;
`endif
                            end
                        end
                    end
`ifdef PKT_CHECKSUM_EN
                    ST_CSUM: begin
                        if (i_rx_byte == csum)
                            o_packet_fully_decoded <= 1'b1;
                        else
                            o_checksum_error <= 1'b1;
                        state <= ST_IDLE;
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
